// File: rtl/seg_scan_ctrl.sv
// Bus-mapped four-digit multiplexed 7-segment scan controller (RIGHT/LEFT/DOTS/CTRL registers).
// Define SEG_SCAN_LZ_BLANK_EN to blank leading-zero digits 3..1.
module seg_scan_ctrl #(
    parameter logic [7:0]  BASE_ADDR = 8'hD0,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  logic [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] DEC_OUT
);

    typedef enum logic [1:0] {ST_OFF, ST_LIT, ST_DARK} state_e;

    localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [17:0] QUARTER   = 18'(SCAN_DIV / 4);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [7:0]  right_q, right_d, left_q, left_d;
    logic [3:0]  dots_q, dots_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  nib_q, nib_d;
    logic        dot_q, dot_d, blank_q, blank_d;
    logic [1:0]  duty_q, duty_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  dec_q, dec_d;

    logic [7:0]  offset;
    logic        in_range, wr_en, rd_en, start;
    logic [1:0]  start_idx;
    logic [15:0] word_d;
    logic [17:0] lit_last;

    assign offset   = BUS_ADDR - BASE_ADDR;
    assign in_range = (offset[7:2] == 6'd0);
    assign wr_en    = BUS_WE & in_range;
    assign rd_en    = ~BUS_WE & in_range;
    assign lit_last = QUARTER * {16'd0, duty_q} + QUARTER - 18'd1;

    // A pending read never fights the bus master during a write cycle.
    assign BUS_DATA   = (rd_valid_q && !BUS_WE) ? rd_data_q : 'z;
    assign SEG_SELECT = sel_q;
    assign DEC_OUT    = dec_q;

    always_comb begin
        right_d    = right_q;
        left_d     = left_q;
        dots_d     = dots_q;
        ctrl_d     = ctrl_q;
        rd_valid_d = rd_en;
        rd_data_d  = '0;
        if (wr_en) begin
            case (offset[1:0])
                2'd0:    right_d = BUS_DATA;
                2'd1:    left_d  = BUS_DATA;
                2'd2:    dots_d  = BUS_DATA[3:0];
                default: ctrl_d  = BUS_DATA[2:0];
            endcase
        end
        case (offset[1:0])
            2'd0:    rd_data_d = right_q;
            2'd1:    rd_data_d = left_q;
            2'd2:    rd_data_d = {4'd0, dots_q};
            default: rd_data_d = {5'd0, ctrl_q};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        nib_d     = nib_q;
        dot_d     = dot_q;
        blank_d   = blank_q;
        duty_d    = duty_q;
        start     = 1'b0;
        start_idx = '0;
        word_d    = {left_d, right_d};
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                idx_d = '0;
                if (ctrl_q[0]) begin
                    state_d = ST_LIT;
                    start   = 1'b1;
                end
            end
            default: begin
                if (!ctrl_q[0]) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == SLOT_LAST) begin
                    state_d   = ST_LIT;
                    cnt_d     = '0;
                    idx_d     = idx_q + 2'd1;
                    start     = 1'b1;
                    start_idx = idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (state_q == ST_LIT && {2'b00, cnt_q} == lit_last)
                        state_d = ST_DARK;
                end
            end
        endcase
        // Latch from the post-write register view so a write on the boundary edge is captured.
        if (start) begin
            nib_d  = word_d[{start_idx, 2'b00} +: 4];
            dot_d  = dots_d[start_idx];
            duty_d = ctrl_d[2:1];
`ifdef SEG_SCAN_LZ_BLANK_EN
            blank_d = (start_idx != 2'd0) && !dots_d[start_idx] &&
                      ((word_d >> {start_idx, 2'b00}) == 16'd0);
`else
            blank_d = 1'b0;
`endif
        end
    end

    always_comb begin
        sel_d = 4'hF;
        dec_d = 8'hFF;
        if (state_q == ST_LIT && !blank_q) begin
            sel_d = ~(4'b0001 << idx_q);
            dec_d = {~dot_q, seg7(nib_q)};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            right_q    <= '0;
            left_q     <= '0;
            dots_q     <= '0;
            ctrl_q     <= 3'b111;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            idx_q      <= '0;
            nib_q      <= '0;
            dot_q      <= 1'b0;
            blank_q    <= 1'b0;
            duty_q     <= '0;
            sel_q      <= 4'hF;
            dec_q      <= 8'hFF;
        end else begin
            right_q    <= right_d;
            left_q     <= left_d;
            dots_q     <= dots_d;
            ctrl_q     <= ctrl_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            nib_q      <= nib_d;
            dot_q      <= dot_d;
            blank_q    <= blank_d;
            duty_q     <= duty_d;
            sel_q      <= sel_d;
            dec_q      <= dec_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: register access plus randomized scan patterns
// against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;

    localparam int         DIV  = 8;
    localparam logic [7:0] BASE = 8'hD0;

    logic       clk = 1'b0;
    logic       rst, we, drive;
    logic [7:0] addr, wdata;
    wire  [7:0] bus_data;
    logic [3:0] sel;
    logic [7:0] dec;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_right, m_left;
    logic [3:0] m_dots;
    logic [2:0] m_ctrl;

    // Active-low g..a glyphs for hex digits 0-F.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    assign bus_data = drive ? wdata : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (bus_data[i]);
    end

    seg_scan_ctrl #(.BASE_ADDR(8'hD0), .SCAN_DIV(DIV)) dut (
        .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(addr),
        .BUS_WE(we), .SEG_SELECT(sel), .DEC_OUT(dec)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input logic [7:0] a, input logic [7:0] d);
        case (8'(a - BASE))
            8'd0: m_right = d;
            8'd1: m_left  = d;
            8'd2: m_dots  = d[3:0];
            8'd3: m_ctrl  = d[2:0];
            default: ;
        endcase
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; wdata = d; we = 1'b1; drive = 1'b1;
        step();
        we = 1'b0; drive = 1'b0; addr = 8'h00;
        model_apply(a, d);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        addr = a; we = 1'b0;
        step();
        d = bus_data;
        addr = 8'h00;
    endtask

    // Called right after the enabling write edge; compares every cycle against the slot model.
    task automatic run_scan(input int n, input int wr_k, input logic [7:0] wr_a, input logic [7:0] wr_d);
        logic [15:0] lw;
        logic [3:0]  ld, nib;
        int          ldu, slot, pos, d;
        logic        lit, blank;
        logic [3:0]  exp_sel;
        logic [7:0]  exp_dec;
        lw = '0; ld = '0; ldu = 0;
        exp_sel = 4'hF; exp_dec = 8'hFF;
        for (int k = 0; k < n; k++) begin
            if (k == wr_k) begin
                addr = wr_a; wdata = wr_d; we = 1'b1; drive = 1'b1;
                model_apply(wr_a, wr_d);
            end
            step();
            we = 1'b0; drive = 1'b0; addr = 8'h00;
            checks++;
            if (sel !== exp_sel) begin
                errors++;
                $display("FAIL scan_sel t=%0d got %h expected %h", k - 1, sel, exp_sel);
            end
            checks++;
            if (dec !== exp_dec) begin
                errors++;
                $display("FAIL scan_dec t=%0d got %h expected %h", k - 1, dec, exp_dec);
            end
            slot = k / DIV;
            pos  = k % DIV;
            d    = slot % 4;
            if (pos == 0) begin
                lw  = {m_left, m_right};
                ld  = m_dots;
                ldu = int'(m_ctrl[2:1]);
            end
            lit   = pos < (DIV / 4) * (ldu + 1);
            nib   = lw[4*d +: 4];
            blank = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
            if (d != 0 && !ld[d] && (lw >> (4 * d)) == 16'h0) blank = 1'b1;
`endif
            if (lit && !blank) begin
                exp_sel = 4'hF ^ (4'b0001 << d);
                exp_dec = {~ld[d], glyph[nib]};
            end else begin
                exp_sel = 4'hF;
                exp_dec = 8'hFF;
            end
        end
    endtask

    task automatic setup_scan(input logic [7:0] r, input logic [7:0] l, input logic [7:0] dt, input logic [1:0] duty);
        bus_write(BASE + 8'd3, 8'h00);
        step();
        bus_write(BASE + 8'd0, r);
        bus_write(BASE + 8'd1, l);
        bus_write(BASE + 8'd2, dt);
        bus_write(BASE + 8'd3, {5'd0, duty, 1'b1});
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (sel !== 4'hF || dec !== 8'hFF) begin
                errors++;
                $display("FAIL reset_outputs got sel=%h dec=%h expected F/FF", sel, dec);
            end
            checks++;
            if (bus_data !== 8'hFF) begin
                errors++;
                $display("FAIL reset_bus_idle got %h expected undriven (FF pulled)", bus_data);
            end
        end
        rst = 1'b0;
        m_right = '0; m_left = '0; m_dots = '0; m_ctrl = 3'b111;
        step();
        checks++;
        if (sel !== 4'hF || dec !== 8'hFF) begin
            errors++;
            $display("FAIL post_reset_outputs got sel=%h dec=%h expected F/FF", sel, dec);
        end
        bus_read(BASE + 8'd3, d);
        checks++;
        if (d !== 8'h07) begin
            errors++;
            $display("FAIL reset_ctrl_read got %h expected 07", d);
        end
    endtask

    task automatic test_registers();
        logic [7:0] d;
        bus_write(BASE + 8'd0, 8'h0F);
        bus_write(BASE + 8'd1, 8'hF0);
        bus_write(BASE + 8'd2, 8'h0F);
        step();
        checks++;
        if (bus_data !== 8'hFF) begin
            errors++;
            $display("FAIL idle_before_read got %h expected undriven (FF pulled)", bus_data);
        end
        bus_read(BASE + 8'd0, d);
        checks++;
        if (d !== 8'h0F) begin errors++; $display("FAIL read_right got %h expected 0F", d); end
        step();
        checks++;
        if (bus_data !== 8'hFF) begin
            errors++;
            $display("FAIL idle_after_read got %h expected undriven (FF pulled)", bus_data);
        end
        bus_read(BASE + 8'd1, d);
        checks++;
        if (d !== 8'hF0) begin errors++; $display("FAIL read_left got %h expected F0", d); end
        bus_read(BASE + 8'd2, d);
        checks++;
        if (d !== 8'h0F) begin errors++; $display("FAIL read_dots got %h expected 0F", d); end
        bus_write(BASE + 8'd2, 8'hA5);
        bus_read(BASE + 8'd2, d);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL read_dots_mask got %h expected 05", d); end
        bus_write(BASE + 8'd3, 8'hFB);
        bus_read(BASE + 8'd3, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL read_ctrl_mask got %h expected 03", d); end
        bus_write(BASE + 8'd4, 8'h55);
        bus_write(BASE - 8'd1, 8'h66);
        bus_read(BASE + 8'd0, d);
        checks++;
        if (d !== 8'h0F) begin errors++; $display("FAIL out_of_range_write got %h expected 0F", d); end
        bus_read(BASE + 8'd4, d);
        checks++;
        if (d !== 8'hFF) begin
            errors++;
            $display("FAIL out_of_range_read got %h expected undriven (FF pulled)", d);
        end
    endtask

    task automatic test_scan_patterns();
        logic [7:0] r, l, dt, wd, wa;
        logic [1:0] duty;
        int wk;
        setup_scan(8'h21, 8'h43, 8'h00, 2'd3);  run_scan(80, -1, 8'h00, 8'h00);
        setup_scan(8'h21, 8'h43, 8'h00, 2'd0);  run_scan(80, -1, 8'h00, 8'h00);
        setup_scan(8'h05, 8'h00, 8'h00, 2'd3);  run_scan(80, -1, 8'h00, 8'h00);
        setup_scan(8'h21, 8'h43, 8'h00, 2'd3);  run_scan(80, 3, BASE, 8'h27);
        setup_scan(8'h21, 8'h43, 8'h00, 2'd3);  run_scan(80, 8, BASE + 8'd2, 8'h02);
        setup_scan(8'h21, 8'h43, 8'h05, 2'd1);  run_scan(80, 5, BASE + 8'd3, 8'h05);
        for (int it = 0; it < 6; it++) begin
            r    = 8'($urandom);
            l    = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 1) == 0) r[7:4] = 4'h0;
            dt   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 15));
            duty = 2'($urandom_range(0, 3));
            wk   = $urandom_range(0, 40);
            wa   = BASE + 8'($urandom_range(0, 3));
            wd   = (wa == BASE + 8'd3) ? {5'd0, 2'($urandom_range(0, 3)), 1'b1} : 8'($urandom);
            setup_scan(r, l, dt, duty);
            run_scan(80, wk, wa, wd);
        end
    endtask

    task automatic test_disable_and_reset();
        logic [7:0] d;
        setup_scan(8'h21, 8'h43, 8'h00, 2'd3);
        for (int i = 0; i < 11; i++) step();
        bus_write(BASE + 8'd3, 8'h00);
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (sel !== 4'hF || dec !== 8'hFF) begin
                errors++;
                $display("FAIL disabled_outputs cyc=%0d got sel=%h dec=%h expected F/FF", i, sel, dec);
            end
        end
        bus_write(BASE + 8'd3, 8'h07);
        step();
        checks++;
        if (sel !== 4'hF) begin errors++; $display("FAIL reenable_lag got sel=%h expected F", sel); end
        step();
        checks++;
        if (sel !== 4'hE || dec !== 8'hF9) begin
            errors++;
            $display("FAIL reenable_digit0 got sel=%h dec=%h expected E/F9", sel, dec);
        end
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (sel !== 4'hF || dec !== 8'hFF) begin
            errors++;
            $display("FAIL midslot_reset got sel=%h dec=%h expected F/FF", sel, dec);
        end
        rst = 1'b0;
        m_right = '0; m_left = '0; m_dots = '0; m_ctrl = 3'b111;
        step();
        checks++;
        if (sel !== 4'hF || dec !== 8'hFF) begin
            errors++;
            $display("FAIL after_midslot_reset got sel=%h dec=%h expected F/FF", sel, dec);
        end
        bus_read(BASE + 8'd0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_right_read got %h expected 00", d); end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; drive = 1'b0; addr = 8'h00; wdata = 8'h00;
        m_right = '0; m_left = '0; m_dots = '0; m_ctrl = 3'b111;
        test_reset();
        test_registers();
        test_scan_patterns();
        test_disable_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
